// File: rtl/io_uart_peripheral_if.sv
// Processor data-bus view of the I/O page: address, store data, byte-lane
// write mask, read strobe, and the registered read data / I/O select that
// the SOC multiplexes against the memory read data.
interface io_uart_peripheral_if;
  logic [31:0] address;
  logic [31:0] writeData;
  logic [3:0]  writeMask;
  logic        read;
  logic [31:0] readData;
  logic        ioSelect;

  // Processor side drives the request and receives the registered response.
  modport master (
    output address, writeData, writeMask, read,
    input  readData, ioSelect
  );

  // Peripheral side decodes the request and returns the registered response.
  modport slave (
    input  address, writeData, writeMask, read,
    output readData, ioSelect
  );
endinterface

// File: rtl/io_uart_peripheral.sv
// Memory-mapped I/O slave: LED output register, 8N1 UART transmitter and
// a status register, decoded on the I/O page (address[IO_BIT] = 1).
//
// Register map (address[3:2]):
//   0 LEDS    R/W, byte-lane writes
//   1 TXDATA  W (byte = writeData[7:0], needs writeMask[0]); reads 0
//   2 STATUS  R  {29'b0, overflow, full, busy}; a read clears overflow
//   3 reserved, reads 0, writes ignored
//
// Build option: define UART_FIFO_EN to replace the single TX holding
// register with a FIFO_DEPTH-entry circular FIFO (FIFO_DEPTH a power of
// two, at least 2).
module io_uart_peripheral #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned IO_BIT       = 22,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  io_uart_peripheral_if.slave  bus,
  output logic [31:0]          LEDS,
  output logic                 txd
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam logic [1:0]  REG_LEDS   = 2'd0;
  localparam logic [1:0]  REG_TXDATA = 2'd1;
  localparam logic [1:0]  REG_STATUS = 2'd2;
  localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       sel;
  logic [1:0] reg_idx;
  logic       wr_en;
  logic       tx_wr;
  logic       status_rd;

  assign sel       = bus.address[IO_BIT];
  assign reg_idx   = bus.address[3:2];
  assign wr_en     = sel && (bus.writeMask != 4'b0000);
  assign tx_wr     = wr_en && (reg_idx == REG_TXDATA) && bus.writeMask[0];
  assign status_rd = bus.read && sel && (reg_idx == REG_STATUS);

  // Only the decoded address bits matter; the rest belong to the memory map.
  logic unused_inputs;
  assign unused_inputs = ^{bus.address, 32'(FIFO_DEPTH)};

  // ---------------------------------------------------------------------
  // TX queue: common handshake
  // ---------------------------------------------------------------------
  tx_state_e  state_q, state_d;
  logic       q_empty;
  logic       q_full;
  logic       q_pop;
  logic       q_push;
  logic [7:0] q_head;
  logic       ovf_set;

  // The FSM drains one byte per IDLE cycle; a pop frees a slot before the
  // same-cycle write is considered, so write-while-full-and-popping fits.
  assign q_pop   = (state_q == ST_IDLE) && !q_empty;
  assign q_push  = tx_wr && (!q_full || q_pop);
  assign ovf_set = tx_wr && q_full && !q_pop;

`ifdef UART_FIFO_EN
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  logic [7:0]  fifo_mem [FIFO_DEPTH];

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign q_empty = (wr_ptr_q == rd_ptr_q);
  assign q_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign q_head  = fifo_mem[rd_ptr_q[AW-1:0]];

  // FIFO pointer advance on push/pop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (q_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (q_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage write.
  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge CLK) begin
    if (q_push) fifo_mem[wr_ptr_q[AW-1:0]] <= bus.writeData[7:0];
  end
`else
  logic       hold_valid_q;
  logic [7:0] hold_data_q;

  assign q_empty = !hold_valid_q;
  assign q_full  = hold_valid_q;
  assign q_head  = hold_data_q;

  // Single holding register: a push refills it even while it is being popped.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= 8'h00;
    end else if (q_push) begin
      hold_valid_q <= 1'b1;
      hold_data_q  <= bus.writeData[7:0];
    end else if (q_pop) begin
      hold_valid_q <= 1'b0;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // LED register and sticky overflow flag
  // ---------------------------------------------------------------------
  logic [31:0] leds_q;
  logic        ovf_q;

  // Byte-lane LED update.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      leds_q <= '0;
    end else if (wr_en && (reg_idx == REG_LEDS)) begin
      for (int n = 0; n < 4; n++) begin
        if (bus.writeMask[n]) leds_q[8*n +: 8] <= bus.writeData[8*n +: 8];
      end
    end
  end

  // Overflow is sticky until a STATUS read; a same-cycle set takes priority.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)         ovf_q <= 1'b0;
    else if (ovf_set)   ovf_q <= 1'b1;
    else if (status_rd) ovf_q <= 1'b0;
  end

  assign LEDS = leds_q;

  // ---------------------------------------------------------------------
  // Read path: one-cycle latency, matching program memory
  // ---------------------------------------------------------------------
  logic        busy;
  logic [31:0] rd_val;
  logic [31:0] read_data_q;
  logic        io_select_q;

  assign busy = (state_q != ST_IDLE) || !q_empty;

  // Register-file read mux.
  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    rd_val = '0;
    case (reg_idx)
      REG_LEDS:   rd_val = leds_q;
      REG_STATUS: rd_val = {29'b0, ovf_q, q_full, busy};
      default:    rd_val = '0;
    endcase
  end

  // Capture read data and the I/O select on a read strobe; hold otherwise.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      read_data_q <= '0;
      io_select_q <= 1'b0;
    end else if (bus.read) begin
      read_data_q <= sel ? rd_val : '0;
      io_select_q <= sel;
    end
  end

  assign bus.readData = read_data_q;
  assign bus.ioSelect = io_select_q;

  // ---------------------------------------------------------------------
  // UART transmitter (8N1)
  // ---------------------------------------------------------------------
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // Transmitter state, counters and registered serial output.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  // Next-state logic; txd_d is the level for the next bit cell so the
  // line changes exactly on the bit boundary.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    case (state_q)
      ST_IDLE: begin
        txd_d  = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (!q_empty) begin
          shift_d = q_head;
          txd_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          txd_d   = shift_q[0];
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = ST_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign txd = txd_q;

endmodule

// File: tb/tb_io_uart_peripheral.sv
// Directed bench for io_uart_peripheral: reset, LED byte lanes, register
// decode, UART frame timing, overflow, FIFO mode (UART_FIFO_EN) and reset
// abort mid-frame. A line monitor decodes every frame on txd.
module tb_io_uart_peripheral;

  localparam int unsigned CLKS_PER_BIT = 16;
  localparam int          FRAME_GAP    = 10 * CLKS_PER_BIT + 1;

  localparam logic [31:0] IO_BASE  = 32'h0040_0000;
  localparam logic [31:0] A_LEDS   = IO_BASE + 32'h0;
  localparam logic [31:0] A_TX     = IO_BASE + 32'h4;
  localparam logic [31:0] A_STATUS = IO_BASE + 32'h8;
  localparam logic [31:0] A_RSVD   = IO_BASE + 32'hC;

  logic        clk;
  logic        rst_n;
  logic [31:0] leds;
  logic        txd;

  io_uart_peripheral_if bus ();

  io_uart_peripheral #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .IO_BIT       (22),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus),
    .LEDS  (leds),
    .txd   (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // -------------------------------------------------------------------
  // Line monitor: on a falling edge, sample 160 negedges and decode.
  // -------------------------------------------------------------------
  logic [7:0]   rx_byte  [$];
  int           rx_time  [$];
  logic         rx_clean [$];
  logic [159:0] smp;
  logic         prev_txd = 1'b1;
  logic         mon_abort;
  logic         mon_clean;
  logic         mon_c;
  logic [7:0]   mon_byte;
  int           mon_t0;

  always begin
    @(negedge clk);
    if (rst_n === 1'b1 && prev_txd === 1'b1 && txd === 1'b0) begin
      mon_t0    = cyc;
      mon_abort = 1'b0;
      smp[0]    = txd;
      for (int j = 1; j < 160; j++) begin
        @(negedge clk);
        if (rst_n !== 1'b1) begin
          mon_abort = 1'b1;
          break;
        end
        smp[j] = txd;
      end
      if (!mon_abort) begin
        mon_clean = 1'b1;
        mon_byte  = 8'h00;
        for (int i = 0; i < 10; i++) begin
          mon_c = smp[16*i + 8];
          for (int k = 0; k < 16; k++)
            if (smp[16*i + k] !== mon_c) mon_clean = 1'b0;
          if (i == 0 && mon_c !== 1'b0) mon_clean = 1'b0;
          if (i == 9 && mon_c !== 1'b1) mon_clean = 1'b0;
          if (i >= 1 && i <= 8) mon_byte[i-1] = mon_c;
        end
        rx_byte.push_back(mon_byte);
        rx_time.push_back(mon_t0);
        rx_clean.push_back(mon_clean);
      end
    end
    prev_txd = txd;
  end

  // -------------------------------------------------------------------
  // Bus helpers: drive on negedge, DUT samples on the following posedge.
  // -------------------------------------------------------------------
  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    bus.address   = addr;
    bus.writeData = data;
    bus.writeMask = mask;
    bus.read      = 1'b0;
    @(negedge clk);
    bus.writeMask = 4'b0000;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic sel);
    @(negedge clk);
    bus.address   = addr;
    bus.writeMask = 4'b0000;
    bus.read      = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    data     = bus.readData;
    sel      = bus.ioSelect;
  endtask

  // Writes n consecutive TXDATA bytes, one per cycle, then raises a STATUS read.
  task automatic tx_burst_then_status(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.address   = A_TX;
      bus.writeData = {24'h0, first + 8'(i)};
      bus.writeMask = 4'b0001;
      bus.read      = 1'b0;
    end
    @(negedge clk);
    bus.writeMask = 4'b0000;
    bus.address   = A_STATUS;
    bus.read      = 1'b1;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (rx_byte.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("frame_count", rx_byte.size(), n);
  endtask

  task automatic check_frame(input int idx, input logic [7:0] exp);
    if (idx < rx_byte.size()) begin
      check($sformatf("rx_byte[%0d]", idx), rx_byte[idx], exp);
      check($sformatf("rx_clean[%0d]", idx), rx_clean[idx], 1'b1);
    end else begin
      check($sformatf("rx_present[%0d]", idx), rx_byte.size(), idx + 1);
    end
  endtask

  task automatic check_gap(input int idx);
    if (idx < rx_time.size())
      check($sformatf("frame_gap[%0d]", idx), rx_time[idx] - rx_time[idx-1], FRAME_GAP);
    else
      check($sformatf("gap_present[%0d]", idx), rx_time.size(), idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rdata;
  logic        rsel;
  logic        busy_all;
  logic        line_high;
  int          base;

  initial begin
    rst_n         = 1'b1;
    bus.address   = '0;
    bus.writeData = '0;
    bus.writeMask = 4'b0000;
    bus.read      = 1'b0;
    #2 rst_n = 1'b0;

    // 1: reset holds state even with write and read traffic.
    bus_write(A_LEDS, 32'hFFFF_FFFF, 4'hF);
    bus_write(A_TX, 32'h0000_00AA, 4'h1);
    @(negedge clk);
    bus.address = A_LEDS;
    bus.read    = 1'b1;
    repeat (2) @(negedge clk);
    bus.read = 1'b0;
    check("rst_leds", leds, 32'h0);
    check("rst_txd", txd, 1'b1);
    check("rst_rdata", bus.readData, 32'h0);
    check("rst_iosel", bus.ioSelect, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(A_STATUS, rdata, rsel);
    check("rst_status", rdata, 32'h0);
    check("rst_status_sel", rsel, 1'b1);

    // 2: LED byte lanes, read latency, hold, decode.
    bus_write(A_LEDS, 32'hA5A5_A5A5, 4'hF);
    check("leds_word", leds, 32'hA5A5_A5A5);
    bus_write(IO_BASE + 32'h1, 32'h3C3C_3C3C, 4'b0010);
    check("leds_byte1", leds, 32'hA5A5_3CA5);
    bus_read(A_LEDS, rdata, rsel);
    check("leds_read", rdata, 32'hA5A5_3CA5);
    check("leds_read_sel", rsel, 1'b1);
    @(negedge clk);
    bus.address = A_STATUS;
    @(negedge clk);
    check("rdata_hold", bus.readData, 32'hA5A5_3CA5);
    check("iosel_hold", bus.ioSelect, 1'b1);
    bus_read(A_TX, rdata, rsel);
    check("txdata_reads0", rdata, 32'h0);
    bus_read(A_RSVD, rdata, rsel);
    check("rsvd_reads0", rdata, 32'h0);
    bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    check("rsvd_wr_ignored", leds, 32'hA5A5_3CA5);
    bus_write(32'h0000_0000, 32'h1234_5678, 4'hF);
    check("mem_wr_ignored", leds, 32'hA5A5_3CA5);
    bus_write(32'h0000_0004, 32'h0000_0055, 4'h1);
    bus_read(32'h0000_0000, rdata, rsel);
    check("mem_read_sel", rsel, 1'b0);
    bus_read(A_STATUS, rdata, rsel);
    check("mem_wr_no_tx", rdata, 32'h0);

    // 3: one frame of 0x55, busy throughout and clear right after.
    base = rx_byte.size();
    bus_write(A_TX, 32'h0000_0055, 4'h1);
    bus.address = A_STATUS;
    bus.read    = 1'b1;
    busy_all    = 1'b1;
    repeat (FRAME_GAP) begin
      @(negedge clk);
      busy_all &= bus.readData[0];
    end
    check("busy_during", busy_all, 1'b1);
    @(negedge clk);
    check("busy_after", bus.readData[0], 1'b0);
    bus.read = 1'b0;
    wait_frames(base + 1, 50);
    check_frame(base, 8'h55);

`ifndef UART_FIFO_EN
    // 4: overflow with the single holding register.
    base = rx_byte.size();
    tx_burst_then_status(8'h41, 3);
    @(negedge clk);
    check("ovf_status", bus.readData, 32'h7);
    @(negedge clk);
    check("ovf_cleared", bus.readData, 32'h3);
    bus.read = 1'b0;
    wait_frames(base + 2, 2 * FRAME_GAP + 50);
    check_frame(base, 8'h41);
    check_frame(base + 1, 8'h42);
    check_gap(base + 1);
    repeat (200) @(negedge clk);
    check("ovf_dropped", rx_byte.size(), base + 2);
    bus_read(A_STATUS, rdata, rsel);
    check("ovf_idle_status", rdata, 32'h0);
`else
    // 5: FIFO absorbs five back-to-back writes; a sixth overflows.
    base = rx_byte.size();
    tx_burst_then_status(8'h01, 5);
    @(negedge clk);
    check("fifo5_status", bus.readData, 32'h3);
    bus.read = 1'b0;
    wait_frames(base + 5, 5 * FRAME_GAP + 50);
    for (int i = 0; i < 5; i++) check_frame(base + i, 8'(i + 1));
    for (int i = 1; i < 5; i++) check_gap(base + i);
    repeat (20) @(negedge clk);
    base = rx_byte.size();
    tx_burst_then_status(8'h11, 6);
    @(negedge clk);
    check("fifo6_status", bus.readData, 32'h7);
    bus.read = 1'b0;
    wait_frames(base + 5, 5 * FRAME_GAP + 50);
    for (int i = 0; i < 5; i++) check_frame(base + i, 8'(8'h11 + i));
    repeat (200) @(negedge clk);
    check("fifo6_dropped", rx_byte.size(), base + 5);
`endif

    // 6: reset during data bit 3 of 0xF0 aborts the frame at once.
    repeat (5) @(negedge clk);
    base = rx_byte.size();
    bus_write(A_TX, 32'h0000_00F0, 4'h1);
    repeat (72) @(negedge clk);
    check("abort_bit3_low", txd, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_txd", txd, 1'b1);
    check("abort_leds", leds, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    bus_read(A_STATUS, rdata, rsel);
    check("abort_status", rdata, 32'h0);
    line_high = 1'b1;
    repeat (400) begin
      @(negedge clk);
      line_high &= txd;
    end
    check("abort_line_idle", line_high, 1'b1);
    check("abort_no_frame", rx_byte.size(), base);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
